// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back register file with write-through bypass, last-write record and retire counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] d2_WB,
  input  logic [ADDR_W-1:0] rd_WB,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              last_valid,
  output logic [ADDR_W-1:0] last_rd,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  retire_count
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic commit;
  assign commit = wb_en && rd_WB != '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      last_valid   <= 1'b0;
      last_rd      <= '0;
      last_data    <= '0;
      retire_count <= '0;
    end else begin
      if (commit) regs[rd_WB] <= d2_WB;
      last_valid <= commit;
      if (commit) begin
        last_rd   <= rd_WB;
        last_data <= d2_WB;
      end
      if (wb_en) retire_count <= retire_count + CNT_W'(1);
    end
  // bypass is gated by wb_en so an undefined d2_WB on idle cycles never reaches the read ports
  assign rdata1 = (reset || rs1 == '0) ? '0 : (wb_en && rd_WB == rs1) ? d2_WB : regs[rs1];
  assign rdata2 = (reset || rs2 == '0) ? '0 : (wb_en && rd_WB == rs2) ? d2_WB : regs[rs2];
endmodule
